// File: rtl/button_press_encoder_pkg.sv
// Shared game package: button count, FSM state encoding and the
// lowest-set-bit index helper used when a press event is captured.
package button_press_encoder_pkg;

    // Number of arcade buttons on the cabinet
    localparam int NUM_BTN = 8;

    // Width of the press index; 3 bits covers up to eight buttons
    localparam int IDX_W = 3;

    // Button vector as seen by the index helper
    typedef logic [NUM_BTN-1:0] btn_vec_t;

    // Press-reporting FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        REPORT  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Index of the lowest set bit, zero when no bit is set
    function automatic logic [IDX_W-1:0] lowest_set_index(input btn_vec_t vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_press_encoder_if.sv
// Press-event handshake between the encoder (master) and the game
// checker (slave). The payload is held while press_valid is high and
// press_ready is low.
interface button_press_encoder_if #(
    parameter int NUM_BTN = 8
);
    logic               press_valid;
    logic               press_ready;
    logic [NUM_BTN-1:0] press_onehot;
    logic [2:0]         press_index;
    logic               press_multi;

    modport master (
        output press_valid,
        output press_onehot,
        output press_index,
        output press_multi,
        input  press_ready
    );

    modport slave (
        input  press_valid,
        input  press_onehot,
        input  press_index,
        input  press_multi,
        output press_ready
    );
endinterface

// File: rtl/button_press_encoder_btn_debounce.sv
// Single-button conditioner: two-flop synchronizer, saturating stability
// counter and the debounced level. Also emits a one-cycle pulse in the
// cycle the debounced level first reads high.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);
    import button_press_encoder_pkg::*;

    // A single-cycle debounce still needs a one-bit counter to exist
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw level, count consecutive disagreeing cycles and
    // flip the debounced level once the disagreement has lasted long enough.
    // The counter clears before it can pass CNT_LAST, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            stable  <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= ~stable;
                rise   <= ~stable;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_press_encoder.sv
// Arcade button press encoder. Debounces each button, captures the set
// of buttons that rose together while armed, and presents that event on
// a valid/ready handshake. After acceptance, no new event is taken until
// every button has been released.
module button_press_encoder #(
    parameter int NUM_BTN         = button_press_encoder_pkg::NUM_BTN,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_BTN-1:0]            btn_raw,
    output logic [NUM_BTN-1:0]            btn_stable,
    button_press_encoder_if.master        press
);
    import button_press_encoder_pkg::*;

    logic [NUM_BTN-1:0] rise;
    logic               rise_any;
    logic               rise_multi;

    state_t             state;
    logic               valid;
    logic [NUM_BTN-1:0] onehot;
    logic [IDX_W-1:0]   index;
    logic               multi;

    // One conditioner per button; they run in every FSM state
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[i]),
            .stable(btn_stable[i]),
            .rise  (rise[i])
        );
    end

    assign rise_any   = |rise;
    // More than one bit set: clearing the lowest set bit leaves something
    assign rise_multi = (rise & (rise - NUM_BTN'(1))) != '0;

    // Press FSM with registered handshake outputs; enable low wins over
    // everything except reset and abandons any unacknowledged event
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            valid  <= 1'b0;
            onehot <= '0;
            index  <= '0;
            multi  <= 1'b0;
        end else if (!enable) begin
            state  <= IDLE;
            valid  <= 1'b0;
            onehot <= '0;
            index  <= '0;
            multi  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_stable == '0) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (rise_any) begin
                        state  <= REPORT;
                        valid  <= 1'b1;
                        onehot <= rise;
                        index  <= lowest_set_index(btn_vec_t'(rise));
                        multi  <= rise_multi;
                    end
                end
                REPORT: begin
                    if (valid && press.press_ready) begin
                        state <= LOCKOUT;
                        valid <= 1'b0;
                    end
                end
                LOCKOUT: begin
                    if (btn_stable == '0) begin
                        state <= ARMED;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign press.press_valid  = valid;
    assign press.press_onehot = onehot;
    assign press.press_index  = index;
    assign press.press_multi  = multi;

endmodule

// File: tb/tb_button_press_encoder.sv
// Directed bench for button_press_encoder with DEBOUNCE_CYCLES=4:
// a table of single presses plus hand-written multi-cycle sequences.
module tb_button_press_encoder;
    import button_press_encoder_pkg::*;

    localparam int NB  = 8;
    localparam int DBC = 4;
    localparam int LAT = 2 + DBC + 1;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_stable;

    int vectors;
    int miscompares;

    button_press_encoder_if #(.NUM_BTN(NB)) bus ();

    button_press_encoder #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DBC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .btn_raw   (btn_raw),
        .btn_stable(btn_stable),
        .press     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] onehot;
        logic [2:0]    index;
        logic          multi;
    } press_vec_t;

    press_vec_t table_v[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Steps until press_valid rises or the budget runs out; returns cycle count
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.press_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;

        table_v[0] = '{raw: 8'h04, onehot: 8'h04, index: 3'd2, multi: 1'b0};
        table_v[1] = '{raw: 8'h41, onehot: 8'h41, index: 3'd0, multi: 1'b1};
        table_v[2] = '{raw: 8'h80, onehot: 8'h80, index: 3'd7, multi: 1'b0};
        table_v[3] = '{raw: 8'h18, onehot: 8'h18, index: 3'd3, multi: 1'b1};
        table_v[4] = '{raw: 8'h01, onehot: 8'h01, index: 3'd0, multi: 1'b0};
        table_v[5] = '{raw: 8'hFF, onehot: 8'hFF, index: 3'd0, multi: 1'b1};

        reset           = 1'b1;
        enable          = 1'b0;
        btn_raw         = '0;
        bus.press_ready = 1'b0;
        steps(2);

        // Reset state
        check("rst_valid", 32'(bus.press_valid), 0);
        check("rst_onehot", 32'(bus.press_onehot), 0);
        check("rst_index", 32'(bus.press_index), 0);
        check("rst_multi", 32'(bus.press_multi), 0);
        check("rst_stable", 32'(btn_stable), 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));

        reset           = 1'b0;
        enable          = 1'b1;
        bus.press_ready = 1'b1;
        step();
        check("armed", 32'(dut.state), 32'(ARMED));

        // Single press 0x04: silent for LAT-1 cycles, then a one-cycle pulse
        btn_raw = 8'h04;
        for (int k = 1; k < LAT; k++) begin
            step();
            check("early_valid", 32'(bus.press_valid), 0);
        end
        step();
        check("s1_valid", 32'(bus.press_valid), 1);
        check("s1_onehot", 32'(bus.press_onehot), 32'h04);
        check("s1_index", 32'(bus.press_index), 2);
        check("s1_multi", 32'(bus.press_multi), 0);
        step();
        check("s1_pulse_end", 32'(bus.press_valid), 0);
        check("s1_stable", 32'(btn_stable), 32'h04);
        btn_raw = '0;
        steps(10);
        check("s1_released", 32'(btn_stable), 0);

        // Bouncing input never settles long enough
        for (int c = 0; c < 20; c++) begin
            btn_raw[0] = ~c[1];
            step();
            check("bounce_stable", 32'(btn_stable[0]), 0);
            check("bounce_valid", 32'(bus.press_valid), 0);
        end
        btn_raw = '0;
        steps(10);

        // Table of presses, each accepted immediately
        for (int t = 0; t < 6; t++) begin
            btn_raw = table_v[t].raw;
            wait_valid(n);
            check("tbl_latency", 32'(n), 32'(LAT));
            check("tbl_onehot", 32'(bus.press_onehot), 32'(table_v[t].onehot));
            check("tbl_index", 32'(bus.press_index), 32'(table_v[t].index));
            check("tbl_multi", 32'(bus.press_multi), 32'(table_v[t].multi));
            step();
            check("tbl_accept", 32'(bus.press_valid), 0);
            btn_raw = '0;
            steps(10);
        end

        // Backpressure: payload held for 10 cycles, accepted on cycle 11
        bus.press_ready = 1'b0;
        btn_raw         = 8'h41;
        wait_valid(n);
        check("bp_latency", 32'(n), 32'(LAT));
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(bus.press_valid), 1);
            check("bp_payload",
                  {20'd0, bus.press_multi, bus.press_index, bus.press_onehot},
                  {20'd0, 1'b1, 3'd0, 8'h41});
            step();
        end
        bus.press_ready = 1'b1;
        step();
        check("bp_accept", 32'(bus.press_valid), 0);

        // Lockout: extra button while others still held is discarded
        btn_raw = 8'hC1;
        for (int k = 0; k < 15; k++) begin
            step();
            check("lock_valid", 32'(bus.press_valid), 0);
        end
        check("lock_stable", 32'(btn_stable), 32'hC1);
        check("lock_state", 32'(dut.state), 32'(LOCKOUT));
        btn_raw = '0;
        steps(10);
        check("lock_rearm", 32'(dut.state), 32'(ARMED));
        btn_raw = 8'h80;
        wait_valid(n);
        check("rearm_latency", 32'(n), 32'(LAT));
        check("rearm_onehot", 32'(bus.press_onehot), 32'h80);
        step();
        btn_raw = '0;
        steps(10);

        // Enable drop while an event is pending
        bus.press_ready = 1'b0;
        btn_raw         = 8'h02;
        wait_valid(n);
        check("en_latency", 32'(n), 32'(LAT));
        enable = 1'b0;
        step();
        check("en_valid", 32'(bus.press_valid), 0);
        check("en_state", 32'(dut.state), 32'(IDLE));
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("en_held_idle", 32'(dut.state), 32'(IDLE));
        end
        btn_raw = '0;
        steps(10);
        check("en_rearm", 32'(dut.state), 32'(ARMED));

        // Reset while an event is pending
        btn_raw = 8'h10;
        wait_valid(n);
        check("rst_latency", 32'(n), 32'(LAT));
        reset   = 1'b1;
        btn_raw = '0;
        step();
        check("mid_valid", 32'(bus.press_valid), 0);
        check("mid_onehot", 32'(bus.press_onehot), 0);
        check("mid_index", 32'(bus.press_index), 0);
        check("mid_multi", 32'(bus.press_multi), 0);
        check("mid_stable", 32'(btn_stable), 0);
        check("mid_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        steps(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
